// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file and its read ports.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_ADDR  = 0;
   localparam int PENDCNT_W  = DEF_ADDR_W + 1;

   // The pending count spans 0..DEPTH inclusive, so it needs one bit more than an address.
   function automatic int pendcnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: word select, pending-bit select, zero-register force and an
// optional write-through compare against the writeback port.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter bit BYPASS   = 1'b0
) (
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    rd_addr_i,
   input  logic [DATA_W-1:0]    words_i [2**ADDR_W],
   input  logic [2**ADDR_W-1:0] pend_i,
   input  logic                 wr_en_i,
   input  logic [ADDR_W-1:0]    wr_addr_i,
   input  logic [DATA_W-1:0]    wr_data_i,
   output logic [DATA_W-1:0]    rd_data_o,
   output logic                 rd_busy_o
);

   logic is_zero;

   assign is_zero = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(ZERO_ADDR));

   // Select stored word and pending bit, then apply write-through and zero/reset forcing.
   always_comb begin
      rd_data_o = words_i[rd_addr_i];
      rd_busy_o = pend_i[rd_addr_i];
      if (BYPASS && wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_o = wr_data_i;
      end
      if (is_zero || rst_i) begin
         rd_data_o = '0;
         rd_busy_o = 1'b0;
      end
   end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: NUM_RD combinational read ports, one write port and a
// per-register pending scoreboard with a live count of pending registers.
// Optional write-through from the write port to the read ports: define REGFILE_BYPASS_EN.
module param_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic [NUM_RD*ADDR_W-1:0]          RdAddr,
   output logic [NUM_RD*DATA_W-1:0]          RdData,
   output logic [NUM_RD-1:0]                 RdBusy,
   input  logic                              WrEn,
   input  logic [ADDR_W-1:0]                 WrAddr,
   input  logic [DATA_W-1:0]                 WrData,
   input  logic                              ResvEn,
   input  logic [ADDR_W-1:0]                 ResvAddr,
   output logic [pendcnt_width(ADDR_W)-1:0]  PendCnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = pendcnt_width(ADDR_W);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [DATA_W-1:0] words_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_ok, resv_ok;
   logic              set_new, clr_old;

   // Writes and reservations aimed at a hard-wired zero register are dropped here.
   assign wr_ok   = WrEn   && !((ZERO_REG != 0) && (WrAddr   == ADDR_W'(ZERO_ADDR)));
   assign resv_ok = ResvEn && !((ZERO_REG != 0) && (ResvAddr == ADDR_W'(ZERO_ADDR)));

   // Word storage: cleared by reset, written on the rising edge.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            words_q[i] <= '0;
         end
      end else if (wr_ok) begin
         words_q[WrAddr] <= WrData;
      end
   end

   // Next pending vector and count; a same-address reserve wins over the writeback clear
   // because the reservation belongs to a younger producer.
   always_comb begin
      pend_d  = pend_q;
      if (wr_ok) begin
         pend_d[WrAddr] = 1'b0;
      end
      if (resv_ok) begin
         pend_d[ResvAddr] = 1'b1;
      end
      set_new = resv_ok && !pend_q[ResvAddr];
      clr_old = wr_ok && pend_q[WrAddr] && !(resv_ok && (ResvAddr == WrAddr));
      cnt_d   = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
   end

   // Scoreboard state registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign PendCnt = cnt_q;

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS_EN)
      ) u_rd (
         .rst_i     (Rst),
         .rd_addr_i (RdAddr[gi*ADDR_W +: ADDR_W]),
         .words_i   (words_q),
         .pend_i    (pend_q),
         .wr_en_i   (wr_ok),
         .wr_addr_i (WrAddr),
         .wr_data_i (WrData),
         .rd_data_o (RdData[gi*DATA_W +: DATA_W]),
         .rd_busy_o (RdBusy[gi])
      );
   end

endmodule

// File: tb/tb_param_register_file.sv
// Randomised and directed bench for param_register_file (default parameters) against an
// array-based reference model of the register file and its scoreboard.
module tb_param_register_file;

   logic        Clk;
   logic        Rst;
   logic [9:0]  RdAddr;
   logic [63:0] RdData;
   logic [1:0]  RdBusy;
   logic        WrEn;
   logic [4:0]  WrAddr;
   logic [31:0] WrData;
   logic        ResvEn;
   logic [4:0]  ResvAddr;
   logic [5:0]  PendCnt;

   int n_checks;
   int n_errors;

   // reference model
   logic [31:0] m_mem [32];
   bit          m_pend [32];

   param_register_file dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .RdAddr   (RdAddr),
      .RdData   (RdData),
      .RdBusy   (RdBusy),
      .WrEn     (WrEn),
      .WrAddr   (WrAddr),
      .WrData   (WrData),
      .ResvEn   (ResvEn),
      .ResvAddr (ResvAddr),
      .PendCnt  (PendCnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += m_pend[i] ? 1 : 0;
      return c;
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (Rst) return 32'h0;
      if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (WrEn && WrAddr == a) return WrData;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (Rst) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = 32'h0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (!Rst) begin
         if (WrEn && WrAddr != 5'd0) begin
            m_mem[WrAddr]  = WrData;
            m_pend[WrAddr] = 1'b0;
         end
         if (ResvEn && ResvAddr != 5'd0) m_pend[ResvAddr] = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [4:0] a0, a1;
      a0 = RdAddr[4:0];
      a1 = RdAddr[9:5];
      check({tag, ".rd0"},  RdData[31:0],  exp_data(a0));
      check({tag, ".rd1"},  RdData[63:32], exp_data(a1));
      check({tag, ".bsy0"}, RdBusy[0],     exp_busy(a0));
      check({tag, ".bsy1"}, RdBusy[1],     exp_busy(a1));
      check({tag, ".cnt"},  PendCnt,       Rst ? 0 : model_cnt());
      $display("txn %s: we=%0b wa=%0d wd=%0h rv=%0b ra=%0d a0=%0d a1=%0d cnt=%0d",
               tag, WrEn, WrAddr, WrData, ResvEn, ResvAddr, a0, a1, PendCnt);
   endtask

   // Called at posedge+1: drive, check pre-edge, clock, update model.
   task automatic step(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re, input logic [4:0] ra,
                       input logic [4:0] a0, input logic [4:0] a1);
      WrEn = we; WrAddr = wa; WrData = wd;
      ResvEn = re; ResvAddr = ra;
      RdAddr = {a1, a0};
      #2;
      check_outputs(tag);
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
      WrEn = 1'b0; ResvEn = 1'b0;
      RdAddr = {a1, a0};
      #1;
   endtask

   task automatic reset_pulse(input string tag);
      Rst = 1'b1;
      model_reset();
      #1;
      check_outputs(tag);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      Rst = 1'b1;
      WrEn = 1'b0; WrAddr = '0; WrData = '0;
      ResvEn = 1'b0; ResvAddr = '0; RdAddr = '0;
      #12 Rst = 1'b0;
      @(posedge Clk);
      #1;
      check_outputs("reset_state");

      // 1: reset mid-cycle wipes data, pending bits and count immediately
      step("t1_wr", 1, 8, 32'hABCDEF98, 1, 3, 8, 3);
      idle(8, 3);
      check("t1_pre_rd", RdData[31:0], 32'hABCDEF98);
      check("t1_pre_cnt", PendCnt, 1);
      WrEn = 1'b1; WrAddr = 5'd8; WrData = 32'h12345678;
      Rst = 1'b1;
      model_reset();
      #1;
      check("t1_rd_in_rst", RdData[31:0], 32'h0);
      check("t1_bsy_in_rst", RdBusy[1], 1'b0);
      check("t1_cnt_in_rst", PendCnt, 0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      idle(8, 3);
      check("t1_wr_lost", RdData[31:0], 32'h0);

      // 2: zero register
      step("t2_r0", 1, 0, 32'hABCDEF98, 1, 0, 0, 0);
      idle(0, 0);
      check("t2_rd0", RdData[31:0], 32'h0);
      check("t2_bsy0", RdBusy[0], 1'b0);
      check("t2_cnt", PendCnt, 0);

      // 3: write then read
      step("t3_w8",  1, 8,  32'h0ECE274A, 0, 0, 0, 0);
      step("t3_w21", 1, 21, 32'h14,       0, 0, 0, 0);
      step("t3_w31", 1, 31, 32'd1000,     0, 0, 0, 0);
      idle(21, 31);
      check("t3_rd21", RdData[31:0],  32'h14);
      check("t3_rd31", RdData[63:32], 32'd1000);
      idle(8, 8);
      check("t3_rd8a", RdData[31:0],  32'h0ECE274A);
      check("t3_rd8b", RdData[63:32], 32'h0ECE274A);

      // 4: scoreboard
      step("t4_r5", 0, 0, 0, 1, 5, 5, 6);
      step("t4_r6", 0, 0, 0, 1, 6, 5, 6);
      idle(5, 6);
      check("t4_cnt2", PendCnt, 2);
      check("t4_bsy5", RdBusy[0], 1'b1);
      step("t4_w5", 1, 5, 32'h55, 0, 0, 5, 6);
      idle(5, 6);
      check("t4_cnt1", PendCnt, 1);
      step("t4_wr6", 1, 6, 32'h66, 1, 6, 6, 5);
      idle(6, 5);
      check("t4_rd6", RdData[31:0], 32'h66);
      check("t4_bsy6", RdBusy[0], 1'b1);
      check("t4_cnt_same", PendCnt, 1);

      // 5: write-through behaviour
      step("t5_w11", 1, 9, 32'h11, 0, 0, 9, 9);
      WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'h22; ResvEn = 1'b0;
      RdAddr = {5'd0, 5'd9};
      #2;
`ifdef REGFILE_BYPASS_EN
      check("t5_pre_edge", RdData[31:0], 32'h22);
`else
      check("t5_pre_edge", RdData[31:0], 32'h11);
`endif
      @(posedge Clk);
      model_edge();
      #1;
      idle(9, 9);
      check("t5_post_edge", RdData[31:0], 32'h22);

      // 6: fill the scoreboard, saturate, drain
      for (int r = 1; r < 32; r++) step("t6_resv", 0, 0, 0, 1, 5'(r), 5'(r), 0);
      idle(1, 2);
      check("t6_full", PendCnt, 31);
      step("t6_rere", 0, 0, 0, 1, 1, 1, 2);
      idle(1, 2);
      check("t6_rere_cnt", PendCnt, 31);
      for (int r = 0; r < 32; r++) step("t6_wr", 1, 5'(r), $urandom, 0, 0, 5'(r), 1);
      idle(1, 2);
      check("t6_empty", PendCnt, 0);

      // randomised traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wa, ra, a0, a1;
         wa = 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 63) == 0) begin
            RdAddr = {a1, a0};
            reset_pulse("rand_rst");
         end else begin
            step("rand", 1'($urandom_range(0, 1)), wa, $urandom,
                 1'($urandom_range(0, 1)), ra, a0, a1);
         end
      end
      idle(0, 1);
      check_outputs("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
